// File: rtl/i2c_ctrl_pkg.sv
// Shared types and constants for the I2C hash transaction controller.
package i2c_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_CMD    = 3'd2,
    ST_DATA   = 3'd3,
    ST_READ   = 3'd4,
    ST_IGNORE = 3'd5
  } state_t;

  localparam logic [7:0] CMD_RESET    = 8'h00;
  localparam logic [7:0] CMD_APPEND   = 8'h01;
  localparam logic [7:0] TX_FILL      = 8'hFF;
  localparam logic [6:0] DEF_I2C_ADDR = 7'h2A;

endpackage

// File: rtl/hash_byte_stage.sv
// Single-entry byte holding register in front of the hasher, with a sticky
// overrun flag for bytes that arrive while the slot is still occupied.
module hash_byte_stage (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       ovr_clr,
  input  logic       ready,
  output logic       can_accept,
  output logic [7:0] data,
  output logic       valid,
  output logic       overrun
);

  // Slot frees up in the same cycle the hasher takes the current byte.
  assign can_accept = !valid || ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data    <= 8'h00;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (load && can_accept) begin
        data  <= load_data;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
      if (ovr_clr)
        overrun <= 1'b0;
      else if (load && !can_accept)
        overrun <= 1'b1;
    end
  end

endmodule

// File: rtl/i2c_hash_txn_controller.sv
// I2C transaction sequencer: address/command decode, write streaming into the
// FNV hasher, and MSB-first readback of a hash snapshot taken at the address.
module i2c_hash_txn_controller
  import i2c_ctrl_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR   = DEF_I2C_ADDR,
  parameter int         HASH_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_strobe,
  input  logic                  stop_strobe,
  input  logic                  rx_byte_valid,
  input  logic [7:0]            rx_byte,
  output logic                  ack_en,
  input  logic                  tx_byte_req,
  output logic [7:0]            tx_byte,
  input  logic                  master_nack,
  output logic [7:0]            hash_data,
  output logic                  hash_valid,
  input  logic                  hash_ready,
  output logic                  hash_init,
  input  logic [HASH_WIDTH-1:0] hash_result,
  output logic                  busy,
  output logic                  overrun
);

  localparam int NBYTES = HASH_WIDTH / 8;
  localparam int IDXW   = $clog2(NBYTES + 1);
  localparam logic [IDXW-1:0] IDX_END = IDXW'(NBYTES);

  state_t                state;
  logic [HASH_WIDTH-1:0] shadow;
  logic [IDXW-1:0]       byte_idx;
  logic                  bus_strobe;
  logic                  data_load;
  logic                  ovr_clr;
  logic                  can_accept;
  logic [7:0]            tx_next;

  assign bus_strobe = start_strobe || stop_strobe;
  assign data_load  = (state == ST_DATA) && rx_byte_valid && !bus_strobe;
  assign ovr_clr    = (state == ST_CMD) && rx_byte_valid && !bus_strobe &&
                      (rx_byte == CMD_RESET) && !hash_valid;

  // Readback byte: shadow MSB byte first, fill once all bytes are sent.
  always_comb begin
    tx_next = TX_FILL;
    if (state == ST_READ) begin
      for (int i = 0; i < NBYTES; i++)
        if (byte_idx == IDXW'(i))
          tx_next = shadow[8*(NBYTES-1-i) +: 8];
    end
  end

  hash_byte_stage u_stage (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (data_load),
    .load_data  (rx_byte),
    .ovr_clr    (ovr_clr),
    .ready      (hash_ready),
    .can_accept (can_accept),
    .data       (hash_data),
    .valid      (hash_valid),
    .overrun    (overrun)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      shadow    <= '0;
      byte_idx  <= '0;
      ack_en    <= 1'b0;
      tx_byte   <= 8'h00;
      hash_init <= 1'b0;
      busy      <= 1'b0;
    end else begin
      hash_init <= 1'b0;
      if (start_strobe) begin
        state  <= ST_ADDR;
        ack_en <= 1'b0;
        busy   <= 1'b1;
      end else if (stop_strobe) begin
        state  <= ST_IDLE;
        ack_en <= 1'b0;
        busy   <= 1'b0;
      end else begin
        if (rx_byte_valid) begin
          unique case (state)
            ST_ADDR: begin
              if (rx_byte[7:1] != I2C_ADDR) begin
                ack_en <= 1'b0;
                state  <= ST_IGNORE;
              end else if (rx_byte[0]) begin
                ack_en   <= 1'b1;
                shadow   <= hash_result;
                byte_idx <= '0;
                state    <= ST_READ;
              end else begin
                ack_en <= 1'b1;
                state  <= ST_CMD;
              end
            end
            ST_CMD: begin
              if (rx_byte == CMD_RESET && !hash_valid) begin
                ack_en    <= 1'b1;
                hash_init <= 1'b1;
                state     <= ST_DATA;
              end else if (rx_byte == CMD_APPEND) begin
                ack_en <= 1'b1;
                state  <= ST_DATA;
              end else begin
                ack_en <= 1'b0;
                state  <= ST_IGNORE;
              end
            end
            ST_DATA: ack_en <= can_accept;
            default: ack_en <= 1'b0;
          endcase
        end
        if (tx_byte_req) begin
          tx_byte <= tx_next;
          if (state == ST_READ && byte_idx != IDX_END)
            byte_idx <= byte_idx + IDXW'(1);
        end
        if (state == ST_READ && master_nack)
          state <= ST_IGNORE;
      end
    end
  end

endmodule

// File: tb/tb_i2c_hash_txn_controller.sv
// Randomized bench: every cycle's outputs are compared with a transaction-level
// model (byte position within the transaction plus a one-slot hasher buffer).
module tb_i2c_hash_txn_controller;

  localparam logic [6:0] ADDR = 7'h2A;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_strobe, stop_strobe, rx_byte_valid, tx_byte_req, master_nack;
  logic [7:0]  rx_byte;
  logic        hash_ready;
  logic [31:0] hash_result;
  logic        ack_en, hash_valid, hash_init, busy, overrun;
  logic [7:0]  tx_byte, hash_data;

  i2c_hash_txn_controller #(.I2C_ADDR(ADDR), .HASH_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_strobe(start_strobe), .stop_strobe(stop_strobe),
    .rx_byte_valid(rx_byte_valid), .rx_byte(rx_byte), .ack_en(ack_en),
    .tx_byte_req(tx_byte_req), .tx_byte(tx_byte), .master_nack(master_nack),
    .hash_data(hash_data), .hash_valid(hash_valid), .hash_ready(hash_ready),
    .hash_init(hash_init), .hash_result(hash_result),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level model
  bit          m_in_txn, m_dead, m_rd, m_pend, m_ovr, m_ack, m_init;
  int          m_pos, m_rd_cnt;
  logic [7:0]  m_pdata, m_txb;
  logic [31:0] m_shadow;

  task automatic mreset();
    m_in_txn = 0; m_dead = 0; m_rd = 0; m_pend = 0; m_ovr = 0; m_ack = 0; m_init = 0;
    m_pos = 0; m_rd_cnt = 0; m_pdata = 8'h00; m_txb = 8'h00; m_shadow = 32'h0;
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".ack_en"},     ack_en,     m_ack);
    chk({ph, ".tx_byte"},    tx_byte,    m_txb);
    chk({ph, ".hash_valid"}, hash_valid, m_pend);
    chk({ph, ".hash_data"},  hash_data,  m_pdata);
    chk({ph, ".hash_init"},  hash_init,  m_init);
    chk({ph, ".busy"},       busy,       m_in_txn);
    chk({ph, ".overrun"},    overrun,    m_ovr);
  endtask

  // One clock: drive inputs, advance the model, check after the edge.
  task automatic cyc(input bit st, input bit sp, input bit rv, input logic [7:0] rb,
                     input bit tr, input bit mn, input bit rdy);
    bit load;
    bit slot_free;
    start_strobe = st; stop_strobe = sp; rx_byte_valid = rv; rx_byte = rb;
    tx_byte_req = tr; master_nack = mn; hash_ready = rdy;
    load = 0;
    slot_free = !m_pend || rdy;
    m_init = 0;
    if (st || sp) begin
      m_in_txn = st; m_pos = 0; m_dead = 0; m_rd = 0; m_ack = 0;
    end else if (m_in_txn && !m_dead) begin
      if (tr) begin
        m_txb = (m_rd && m_rd_cnt < 4) ? m_shadow[8*(3-m_rd_cnt) +: 8] : 8'hFF;
        if (m_rd && m_rd_cnt < 4) m_rd_cnt++;
      end
      if (m_rd && mn) m_dead = 1;
      else if (rv) begin
        if (m_pos == 0) begin
          m_ack = (rb[7:1] == ADDR);
          if (!m_ack) m_dead = 1;
          else if (rb[0]) begin m_rd = 1; m_shadow = hash_result; m_rd_cnt = 0; end
        end else if (m_rd) begin
          m_ack = 0;
        end else if (m_pos == 1) begin
          if (rb == 8'h00 && !m_pend) begin m_ack = 1; m_init = 1; m_ovr = 0; end
          else if (rb == 8'h01) m_ack = 1;
          else begin m_ack = 0; m_dead = 1; end
        end else begin
          m_ack = slot_free;
          if (slot_free) load = 1; else m_ovr = 1;
        end
        m_pos++;
      end
    end else begin
      if (rv) m_ack = 0;
      if (tr) m_txb = 8'hFF;
    end
    if (load) begin m_pend = 1; m_pdata = rb; end
    else if (m_pend && rdy) m_pend = 0;
    @(posedge clk); #1;
    start_strobe = 0; stop_strobe = 0; rx_byte_valid = 0; tx_byte_req = 0; master_nack = 0;
    check_all("cyc");
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 8'h00, 0, 0, rdy);
  endtask
  task automatic sbyte(input logic [7:0] b, input bit rdy); cyc(0, 0, 1, b, 0, 0, rdy); endtask
  task automatic treq(input bit rdy);                       cyc(0, 0, 0, 8'h00, 1, 0, rdy); endtask
  task automatic start(input bit rdy);                      cyc(1, 0, 0, 8'h00, 0, 0, rdy); endtask
  task automatic stop(input bit rdy);                       cyc(0, 1, 0, 8'h00, 0, 0, rdy); endtask

  initial begin
    start_strobe = 0; stop_strobe = 0; rx_byte_valid = 0; rx_byte = 0;
    tx_byte_req = 0; master_nack = 0; hash_ready = 1; hash_result = 0;
    rst_n = 0; mreset();
    #23; check_all("reset");
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // Write: RESET cmd then two payload bytes
    start(1); sbyte(8'h54, 1); sbyte(8'h00, 1); sbyte(8'h61, 1); sbyte(8'h62, 1);
    idle(2, 1); stop(1); idle(1, 1);

    // Wrong address: everything NACKed, fill on reads
    start(1); sbyte(8'h56, 1); sbyte(8'h00, 1); sbyte(8'h33, 1); treq(1); stop(1);

    // Read: snapshot is fixed at the address byte
    hash_result = 32'h050C5D7E;
    start(1); sbyte(8'h55, 1);
    hash_result = 32'hDEADBEEF;
    for (int i = 0; i < 5; i++) begin treq(1); idle(1, 1); end
    chk("read.shadow_last", tx_byte, 8'hFF);
    stop(1);

    // Overrun with a stalled hasher, then cleared by a new RESET command
    start(0); sbyte(8'h54, 0); sbyte(8'h00, 0); sbyte(8'h10, 0); sbyte(8'h11, 0);
    chk("ovr.set", overrun, 1'b1);
    stop(0); idle(2, 1);
    start(1); sbyte(8'h54, 1); sbyte(8'h00, 1);
    chk("ovr.clr", overrun, 1'b0);

    // Repeated START together with STOP mid-DATA
    sbyte(8'h20, 1); cyc(1, 1, 0, 8'h00, 0, 0, 1);
    chk("rs.busy", busy, 1'b1);

    // Async reset in the middle of a read
    sbyte(8'h55, 1); treq(1);
    #2 rst_n = 0; #1; mreset(); check_all("async_rst");
    @(negedge clk); rst_n = 1; @(posedge clk); #1;

    // APPEND after a finished transaction, then an illegal command
    start(1); sbyte(8'h54, 1); sbyte(8'h00, 1); sbyte(8'hA5, 1); stop(1);
    start(1); sbyte(8'h54, 1); sbyte(8'h01, 1); sbyte(8'h5A, 1); stop(1);
    start(1); sbyte(8'h54, 1); sbyte(8'h7F, 1); sbyte(8'h01, 1); sbyte(8'h02, 1); treq(1); stop(1);

    // Randomized transactions
    for (int t = 0; t < 250; t++) begin
      bit rw;
      logic [6:0] a;
      rw = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 4) == 0) ? 7'($urandom()) : ADDR;
      hash_result = $urandom();
      start(1'($urandom_range(0, 3) != 0));
      sbyte({a, rw}, 1'($urandom_range(0, 3) != 0));
      hash_result = $urandom();
      if (rw) begin
        for (int k = 0; k < int'($urandom_range(1, 6)); k++) begin
          cyc(0, 0, 0, 8'h00, 1, ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));
          idle($urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end
      end else begin
        int c;
        c = $urandom_range(0, 5);
        sbyte((c < 2) ? 8'h00 : (c < 4) ? 8'h01 : 8'($urandom()), 1'($urandom_range(0, 1)));
        for (int k = 0; k < int'($urandom_range(0, 6)); k++) begin
          sbyte(8'($urandom()), 1'($urandom_range(0, 3) != 0));
          idle($urandom_range(0, 2), 1'($urandom_range(0, 3) != 0));
        end
      end
      case ($urandom_range(0, 5))
        0:       cyc(1, 1, 0, 8'h00, 0, 0, 1);
        1:       cyc(0, 1, 1, 8'($urandom()), 0, 0, 1);
        2:       cyc(1, 0, 1, 8'($urandom()), 1, 0, 1);
        default: stop(1);
      endcase
      idle($urandom_range(0, 2), 1);
      stop(1);
      idle(2, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/i2c_hash_txn_controller.md
Name: i2c_hash_txn_controller

Overview:
Transaction-level sequencer between the I2C bus-condition and byte layer (start/stop strobes, received and transmitted bytes) and the FNV hasher core.
- Decodes the address byte and R/W bit, then a command byte.
- Streams write payload bytes into the hasher through a valid/ready handshake.
- Serves the hash result back to the controller on reads.
- Makes every ACK/NACK decision for received bytes.

Parameters:
I2C_ADDR, 7'h2A, 7-bit target address matched against rx_byte[7:1].
HASH_WIDTH, 32, hash result width; must be a multiple of 8; NBYTES = HASH_WIDTH/8.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
start_strobe  in  1  one-cycle pulse: START or repeated START detected.
stop_strobe  in  1  one-cycle pulse: STOP detected.
rx_byte_valid  in  1  one-cycle pulse: rx_byte is complete.
rx_byte  in  8  received byte, MSB first on the wire.
ack_en  out  1  registered; 1 = drive ACK for the last rx byte; valid the cycle after rx_byte_valid.
tx_byte_req  in  1  one-cycle pulse: byte layer needs the next read byte.
tx_byte  out  8  registered; valid the cycle after tx_byte_req.
master_nack  in  1  one-cycle pulse: controller NACKed the last tx byte.
hash_data  out  8  byte presented to the hasher.
hash_valid  out  1  hash_data valid; held until accepted.
hash_ready  in  1  hasher accepts when hash_valid && hash_ready.
hash_init  out  1  one-cycle pulse: reload the FNV offset basis.
hash_result  in  HASH_WIDTH  current hash value.
busy  out  1  state != IDLE.
overrun  out  1  sticky; a data byte arrived while hash_valid was still pending.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - Outputs ack_en, tx_byte, hash_data, hash_valid, hash_init, busy, overrun all 0.
  - byte_idx=0; shadow=0.
  - A pending hash_valid is dropped; the hasher tolerates this.
- States: IDLE, ADDR, CMD, DATA, READ, IGNORE.
- Global transitions, checked before any per-state transition:
  - start_strobe → ADDR from any state.
  - stop_strobe → IDLE from any state.
  - start_strobe and stop_strobe in the same cycle: start wins → ADDR.
  - A bus strobe in the same cycle as rx_byte_valid: the strobe wins and the byte is discarded (ack_en=0).
- ADDR, on rx_byte_valid:
  - rx_byte[7:1] != I2C_ADDR: ack_en=0 → IGNORE.
  - Address match with R/W=0: ack_en=1 → CMD.
  - Address match with R/W=1: ack_en=1; shadow <= hash_result; byte_idx <= 0 → READ.
- CMD, on rx_byte_valid:
  - 0x00 (RESET) with no pending byte: hash_init pulses 1 cycle; overrun cleared; ack_en=1 → DATA.
  - 0x00 with pending byte: ack_en=0 → IGNORE.
  - 0x01 (APPEND): ack_en=1 → DATA; the hash is not reinitialised.
  - Any other value: ack_en=0 → IGNORE.
- DATA, on rx_byte_valid:
  - hash_valid=0, or hash_valid && hash_ready in that same cycle: hash_data <= rx_byte; hash_valid <= 1 next cycle; ack_en=1.
  - Otherwise: byte dropped; ack_en=0; overrun <= 1; stay in DATA.
  - Handshake: hash_valid deasserts the cycle after hash_valid && hash_ready, unless it is reloaded in that cycle.
- READ:
  - On tx_byte_req: tx_byte <= shadow byte NBYTES-1-byte_idx (MSB byte first) while byte_idx < NBYTES, then 8'hFF.
  - byte_idx increments and saturates at NBYTES.
  - master_nack → IGNORE.
- IGNORE: ack_en=0 for all bytes and tx_byte=8'hFF until the next bus strobe.
- ack_en holds its value until the next rx_byte_valid or bus strobe; a bus strobe clears it to 0.
- hash_init and a new hash_valid are never asserted in the same cycle.
- Latency from rx_byte_valid to ack_en is 1 cycle; to hash_valid is 1 cycle.

Decomposition:
- Package i2c_ctrl_pkg holds:
  - the state enum (3 bits);
  - CMD_RESET=8'h00 and CMD_APPEND=8'h01;
  - TX_FILL=8'hFF;
  - the default target address.
- Sub-module hash_byte_stage: a single-entry holding register with the valid/ready handshake, a load input and an overrun flag. It is instantiated once.

Test Plan:
- START; addr 0x54 (0x2A<<1|0); cmd 0x00; bytes 0x61, 0x62; STOP, with hash_ready=1 → ack_en=1 on all 4 bytes; one hash_init pulse; hash_data 0x61 then 0x62, one cycle each; busy=0 after STOP.
- START; addr 0x56 (wrong) → ack_en=0; subsequent bytes NACKed; no hash_valid and no hash_init; tx_byte=0xFF on tx_byte_req.
- hash_result=32'h050C5D7E; START; addr 0x55; 5 tx_byte_req → tx_byte 0x05, 0x0C, 0x5D, 0x7E, 0xFF; hash_result changing after the address byte does not alter the bytes returned.
- In DATA with hash_ready=0: bytes 0x10, 0x11 → first byte ACKed and held on hash_data; second NACKed and overrun=1; a following cmd 0x00 in a new transaction clears overrun.
- Mid-DATA repeated START in the same cycle as stop_strobe → state ADDR and busy=1; rst_n low mid-READ → all outputs 0 asynchronously, state IDLE.
- cmd 0x01 after a prior 0x00 transaction → no hash_init; the byte is appended; cmd 0x7F → NACK and IGNORE until STOP.
